rv_slave_fifo: RTL and testbench

RV_SLAVE_FIFO -- requirements
Module: rv_slave_fifo

---
 rtl/rv_slave_fifo_if.sv | 36 +++
 rtl/rv_slave_fifo.sv | 125 ++++++++++++
 tb/tb_rv_slave_fifo.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_slave_fifo_if.sv
// Ready/valid bus bundle for rv_slave_fifo: an upstream (s_*) channel into the
// FIFO and a downstream (m_*) channel out of it.
//
// Handshake: a beat moves on a channel exactly on a rising clock edge where
// valid and ready are both 1. Once raised, valid and its data hold stable until
// that edge; ready may change freely and never depends combinationally on valid.
interface rv_slave_fifo_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    // The FIFO itself: receives on s_*, sources on m_*.
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output m_valid,
        output m_data,
        input  m_ready
    );

    // The environment around the FIFO: drives upstream beats, consumes downstream.
    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/rv_slave_fifo.sv
// First-word fall-through ready/valid FIFO with a registered upstream ready,
// an accepted-beat counter and a sticky data-sequence checker
// (each pushed byte is expected to be the previous pushed byte plus one).
module rv_slave_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     aclk,
    input  logic                     rstn,
    rv_slave_fifo_if.slave           bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              rx_count,
    output logic                     seq_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Storage and pointers. Pointers are exactly AW bits so they wrap from
    // DEPTH-1 to 0 by plain binary overflow (DEPTH is a power of two).
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;

    // s_ready is a flop holding "next level < DEPTH", so it never depends on
    // m_ready within the same cycle.
    logic              s_ready_q, s_ready_d;

    // Statistics and sequence checking.
    logic [15:0]       rx_count_q, rx_count_d;
    logic              seq_err_q, seq_err_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] exp_q, exp_d;

    logic              push;
    logic              pop;
    logic              not_empty;

    assign not_empty = (level_q != '0);
    assign push      = bus.s_valid && s_ready_q;
    assign pop       = not_empty && bus.m_ready;

    // Occupancy, pointer and registered-ready next state.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        s_ready_d = (level_d < LW'(DEPTH));
    end

    // Storage write: only the slot under the write pointer changes on a push.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.s_data;
        end
    end

    // Beat counter and sequence checker; the first push after reset only
    // primes the expected value, every later push is compared against it.
    always_comb begin
        rx_count_d = rx_count_q;
        seq_err_d  = seq_err_q;
        first_d    = first_q;
        exp_d      = exp_q;
        if (push) begin
            rx_count_d = rx_count_q + 16'd1;
            if (first_q) begin
                first_d = 1'b0;
            end else if (bus.s_data != exp_q) begin
                seq_err_d = 1'b1;
            end
            exp_d = bus.s_data + DATA_W'(1);
        end
    end

    // Control state: async reset empties the FIFO immediately.
    always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            s_ready_q  <= 1'b0;
            rx_count_q <= '0;
            seq_err_q  <= 1'b0;
            first_q    <= 1'b1;
            exp_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            s_ready_q  <= s_ready_d;
            rx_count_q <= rx_count_d;
            seq_err_q  <= seq_err_d;
            first_q    <= first_d;
            exp_q      <= exp_d;
        end
    end

    // Data storage has no reset: contents are only visible while level != 0.
    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

    // Outputs: head entry is presented directly (fall-through), zero when empty.
    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = not_empty;
    assign bus.m_data  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign level       = level_q;
    assign rx_count    = rx_count_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_rv_slave_fifo.sv
// Bench for rv_slave_fifo: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_rv_slave_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic rstn = 1'b0;
  always #5 aclk = ~aclk;

  logic [LW-1:0] level;
  logic [15:0]   rx_count;
  logic          seq_err;

  rv_slave_fifo_if #(.DATA_W(DATA_W)) bus ();

  rv_slave_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .aclk     (aclk),
    .rstn     (rstn),
    .bus      (bus),
    .level    (level),
    .rx_count (rx_count),
    .seq_err  (seq_err)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [15:0]       m_rx;
  bit                m_seq;
  bit                m_first;
  bit                m_in_reset;
  logic [DATA_W-1:0] m_expd;
  bit                last_push;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    exp_q.delete();
    m_rx       = '0;
    m_seq      = 1'b0;
    m_first    = 1'b1;
    m_in_reset = 1'b1;
    m_expd     = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("s_ready", 32'(bus.s_ready), 32'(!m_in_reset && exp_q.size() < DEPTH));
    check_val("m_valid", 32'(bus.m_valid), 32'(exp_q.size() != 0));
    check_val("level", 32'(level), 32'(exp_q.size()));
    check_val("rx_count", 32'(rx_count), 32'(m_rx));
    check_val("seq_err", 32'(seq_err), 32'(m_seq));
    if (exp_q.size() != 0) check_val("m_data", 32'(bus.m_data), 32'(exp_q[0]));
    else if (!rstn) check_val("m_data_rst", 32'(bus.m_data), 32'd0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive inputs, advance the model over the next rising
  // edge, then check outputs on the following negedge.
  task automatic step(input bit sv, input logic [DATA_W-1:0] sd, input bit mr);
    bit push, pop;
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.m_ready = mr;
    push = sv && !m_in_reset && (exp_q.size() < DEPTH);
    pop  = mr && (exp_q.size() != 0);
    last_push = push;
    @(posedge aclk);
    m_in_reset = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back(sd);
      m_rx = m_rx + 16'd1;
      if (m_first) m_first = 1'b0;
      else if (sd !== m_expd) m_seq = 1'b1;
      m_expd = sd + 8'd1;
    end
    @(negedge aclk);
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      @(negedge aclk);
      check_outputs();
    end
    rstn = 1'b1;
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] d;
    int n;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    model_reset();

    // Reset held for 10 cycles, then s_ready rises at the first live edge.
    do_reset(10);
    check_val("s_ready_after_reset", 32'(bus.s_ready), 32'd1);

    // Three sequential beats with the sink always ready.
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h02, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check_val("rx_after_3", 32'(rx_count), 32'd3);
    check_val("seq_after_3", 32'(seq_err), 32'd0);
    check_val("level_after_3", 32'(level), 32'd0);

    // Five beats into a stalled sink: fifth is held upstream until room.
    d = 8'h03;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, d, 1'b0);
      if (last_push) d = d + 8'd1;
    end
    check_val("full_level", 32'(level), 32'(DEPTH));
    check_val("full_s_ready", 32'(bus.s_ready), 32'd0);
    check_val("full_m_data_held", 32'(bus.m_data), 32'h03);
    for (int i = 0; i < 8 && d != 8'h08; i++) begin
      step(1'b1, d, 1'b1);
      if (last_push) d = d + 8'd1;
    end
    check_val("beat5_accepted", 32'(d), 32'h08);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Full FIFO with source and sink both always active for 20+ beats.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, d, 1'b0);
      if (last_push) d = d + 8'd1;
    end
    n = 0;
    for (int i = 0; i < 30 && n < 20; i++) begin
      step(1'b1, d, 1'b1);
      if (last_push) begin
        d = d + 8'd1;
        n++;
      end
    end
    check_val("stream_20_pushes", 32'(n), 32'd20);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Sequence error is sticky and does not block data.
    do_reset(3);
    step(1'b1, 8'h10, 1'b1);
    check_val("seq_first", 32'(seq_err), 32'd0);
    step(1'b1, 8'h12, 1'b1);
    check_val("seq_gap", 32'(seq_err), 32'd1);
    step(1'b1, 8'h13, 1'b1);
    check_val("seq_sticky", 32'(seq_err), 32'd1);
    check_val("seq_data_flows", 32'(bus.m_data), 32'h13);

    // Asynchronous reset with three entries buffered.
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h21, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_val("pre_rst_level", 32'(level), 32'd3);
    #3;
    rstn = 1'b0;
    #1;
    check_val("arst_m_valid", 32'(bus.m_valid), 32'd0);
    check_val("arst_level", 32'(level), 32'd0);
    check_val("arst_rx_count", 32'(rx_count), 32'd0);
    check_val("arst_seq_err", 32'(seq_err), 32'd0);
    bus.s_valid = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      check_outputs();
    end
    rstn = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'h55, 1'b1);
    check_val("post_arst_seq", 32'(seq_err), 32'd0);
    step(1'b0, '0, 1'b1);

    // Random traffic; data mostly sequential with occasional jumps.
    d = 8'h56;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
      if (last_push) begin
        if ($urandom_range(0, 15) == 0) d = 8'($urandom_range(0, 255));
        else d = d + 8'd1;
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // 0x10000 pushes: rx_count wraps to zero, data wraps 0xFF->0x00 cleanly.
    do_reset(3);
    d = 8'hF0;
    n = 0;
    for (int i = 0; i < 32'h10000 + 16 && n < 32'h10000; i++) begin
      step(1'b1, d, 1'b1);
      if (last_push) begin
        d = d + 8'd1;
        n++;
      end
    end
    check_val("wrap_push_count", 32'(n), 32'h10000);
    check_val("rx_wrap", 32'(rx_count), 32'd0);
    check_val("wrap_seq_err", 32'(seq_err), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
